// File: rtl/usb_tx_serializer.sv
// USB full-speed transmit serializer: SYNC, LSB-first data with bit stuffing,
// NRZI line coding and EOP, driving D+/D- with a pad output enable.
`timescale 1ns/1ps
module usb_tx_serializer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       dp,
    output logic       dm,
    output logic       tx_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_PRE  = TW'(CLKS_PER_BIT - 2);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        DATA    = 3'd2,
        STUFF   = 3'd3,
        EOP_SE0 = 3'd4,
        EOP_J   = 3'd5
    } state_t;

    state_t        state_r, state_s;
    logic [TW-1:0] timer_r, timer_s;
    logic [3:0]    idx_r, idx_s;
    logic [7:0]    shift_r, shift_s;
    logic [2:0]    ones_r, ones_s;
    logic          last_r, last_s;
    logic          level_r, level_s;
    logic          dp_r, dp_s, dm_r, dm_s, oe_r, oe_s;
    logic          ready_r, ready_s, done_r, done_s, err_r, err_s;
    logic          boundary_s, pre_s, stuff_need_s, at_byte_end_s;
    logic [2:0]    ones_upd_s;

    // NRZI: a 0 toggles the line level, a 1 holds it (level 1 = J)
    function automatic logic nrzi(input logic level, input logic bit_v);
        return bit_v ? level : ~level;
    endfunction

    assign boundary_s    = (timer_r == T_LAST);
    assign pre_s         = (timer_r == T_PRE);
    assign stuff_need_s  = shift_r[0] && (ones_r == 3'd5);
    assign ones_upd_s    = shift_r[0] ? (ones_r + 3'd1) : 3'd0;
    // A byte ends after the last SYNC bit, a final data bit with no stuff due, or a trailing stuff bit
    assign at_byte_end_s = ((state_r == SYNC)  && (idx_r == 4'd7)) ||
                           ((state_r == DATA)  && (idx_r == 4'd7) && !stuff_need_s) ||
                           ((state_r == STUFF) && (idx_r == 4'd8));

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, bit sequencing and line symbol selection
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        shift_s = shift_r;
        ones_s  = ones_r;
        last_s  = last_r;
        level_s = level_r;
        dp_s    = dp_r;
        dm_s    = dm_r;
        oe_s    = oe_r;
        done_s  = 1'b0;
        if (state_r == IDLE) begin
            timer_s = '0;
        end else if (boundary_s) begin
            timer_s = '0;
        end else begin
            timer_s = timer_r + TW'(1);
        end
        // Handshake is decided one cycle early so tx_ready/tx_err are registered yet land on the boundary
        if (pre_s && at_byte_end_s && !last_r) begin
            ready_s = tx_valid;
            err_s   = ~tx_valid;
        end else begin
            ready_s = 1'b0;
            err_s   = 1'b0;
        end
        if (boundary_s && at_byte_end_s) begin
            if (state_r == DATA) begin
                ones_s = ones_upd_s;
            end else begin
                ones_s = ones_r;
            end
            if (ready_r) begin
                state_s = DATA;
                shift_s = tx_data;
                last_s  = tx_last;
                idx_s   = 4'd0;
                level_s = nrzi(level_r, tx_data[0]);
                {dp_s, dm_s} = {level_s, ~level_s};
            end else begin
                state_s = EOP_SE0;
                idx_s   = 4'd0;
                {dp_s, dm_s} = 2'b00;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (tx_valid && !done_r) begin
                        state_s = SYNC;
                        idx_s   = 4'd0;
                        ones_s  = 3'd0;
                        last_s  = 1'b0;
                        oe_s    = 1'b1;
                        level_s = nrzi(1'b1, 1'b0);
                        {dp_s, dm_s} = {level_s, ~level_s};
                    end else begin
                        state_s = IDLE;
                    end
                end
                SYNC: begin
                    if (boundary_s) begin
                        idx_s   = idx_r + 4'd1;
                        level_s = nrzi(level_r, idx_r == 4'd6);
                        {dp_s, dm_s} = {level_s, ~level_s};
                    end else begin
                        state_s = SYNC;
                    end
                end
                DATA: begin
                    if (boundary_s) begin
                        shift_s = {1'b0, shift_r[7:1]};
                        idx_s   = idx_r + 4'd1;
                        if (stuff_need_s) begin
                            state_s = STUFF;
                            ones_s  = 3'd0;
                            level_s = nrzi(level_r, 1'b0);
                        end else begin
                            ones_s  = ones_upd_s;
                            level_s = nrzi(level_r, shift_r[1]);
                        end
                        {dp_s, dm_s} = {level_s, ~level_s};
                    end else begin
                        state_s = DATA;
                    end
                end
                STUFF: begin
                    if (boundary_s) begin
                        state_s = DATA;
                        level_s = nrzi(level_r, shift_r[0]);
                        {dp_s, dm_s} = {level_s, ~level_s};
                    end else begin
                        state_s = STUFF;
                    end
                end
                EOP_SE0: begin
                    if (boundary_s && (idx_r == 4'd1)) begin
                        state_s = EOP_J;
                        level_s = 1'b1;
                        {dp_s, dm_s} = 2'b10;
                    end else if (boundary_s) begin
                        idx_s = idx_r + 4'd1;
                    end else begin
                        state_s = EOP_SE0;
                    end
                end
                EOP_J: begin
                    if (boundary_s) begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                        oe_s    = 1'b0;
                        level_s = 1'b1;
                        {dp_s, dm_s} = 2'b10;
                    end else begin
                        state_s = EOP_J;
                    end
                end
                default: begin
                    state_s = IDLE;
                    oe_s    = 1'b0;
                    level_s = 1'b1;
                    {dp_s, dm_s} = 2'b10;
                end
            endcase
        end
    end

    // Datapath and registered outputs; reset parks the line at J with the pads released
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            timer_r <= '0;
            idx_r   <= 4'd0;
            shift_r <= 8'd0;
            ones_r  <= 3'd0;
            last_r  <= 1'b0;
            level_r <= 1'b1;
            dp_r    <= 1'b1;
            dm_r    <= 1'b0;
            oe_r    <= 1'b0;
            ready_r <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            timer_r <= timer_s;
            idx_r   <= idx_s;
            shift_r <= shift_s;
            ones_r  <= ones_s;
            last_r  <= last_s;
            level_r <= level_s;
            dp_r    <= dp_s;
            dm_r    <= dm_s;
            oe_r    <= oe_s;
            ready_r <= ready_s;
            done_r  <= done_s;
            err_r   <= err_s;
        end
    end

    assign tx_ready = ready_r;
    assign dp       = dp_r;
    assign dm       = dm_r;
    assign tx_oe    = oe_r;
    assign tx_done  = done_r;
    assign tx_err   = err_r;
    assign tx_busy  = (state_r != IDLE);

endmodule
